// File: rtl/switch_sequence_recorder.sv
// Slide-switch input stage: two-flop sync, per-bit debounce, and an ordered record of
// switch turn-on events within an arm/close capture window.
module switch_sequence_recorder #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEPTH      = 8,
  parameter int IDX_W      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               sw,
  input  logic                     arm,
  input  logic                     close,
  output logic [7:0]               sw_stable,
  output logic [DEPTH*IDX_W-1:0]   seq_data,
  output logic [3:0]               seq_len,
  output logic                     seq_done,
  output logic                     overflow
);

  localparam int              CNT_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [3:0]      DEPTH_L = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               sync1_q, sync2_q;
  logic [7:0]               stable_q, stable_d, stable_prev_q;
  logic [CNT_W-1:0]         cnt_q [8];
  logic [CNT_W-1:0]         cnt_d [8];
  logic [7:0]               pend_q, pend_d;
  logic [DEPTH*IDX_W-1:0]   data_q, data_d;
  logic [3:0]               len_q, len_d;
  logic                     ovf_q, ovf_d;

  logic [7:0]               rise, eff, pick_mask;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_vld;

  // A level must differ from the stable value for DEB_CYCLES consecutive cycles to take effect.
  always_comb begin
    stable_d = stable_q;
    for (int n = 0; n < 8; n++) begin
      cnt_d[n] = '0;
      if (sync2_q[n] != stable_q[n]) begin
        if (cnt_q[n] == CNT_MAX) stable_d[n] = sync2_q[n];
        else                     cnt_d[n]    = cnt_q[n] + 1'b1;
      end
    end
  end

  // Current-cycle rises join the pending set so a lone rise is appended one cycle after it shows.
  assign rise = stable_q & ~stable_prev_q;
  assign eff  = pend_q | rise;

  always_comb begin
    pick_vld = |eff;
    pick_idx = '0;
    for (int n = 7; n >= 0; n--) begin
      if (eff[n]) pick_idx = IDX_W'(n);
    end
    pick_mask = 8'd1 << pick_idx;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | rise;
    data_d  = data_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = CAPTURE;
          data_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          pend_d  = '0;
        end
      end
      CAPTURE: begin
        pend_d = eff & ~pick_mask;
        if (pick_vld) begin
          if (len_q < DEPTH_L) begin
            data_d[len_q*IDX_W +: IDX_W] = pick_idx;
            len_d = len_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        // Anything still queued at close is lost and flagged.
        if (close) begin
          state_d = DONE;
          if (pend_d != 8'd0) ovf_d = 1'b1;
          pend_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int n = 0; n < 8; n++) cnt_q[n] <= '0;
      pend_q        <= '0;
      data_q        <= '0;
      len_q         <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int n = 0; n < 8; n++) cnt_q[n] <= cnt_d[n];
      pend_q        <= pend_d;
      data_q        <= data_d;
      len_q         <= len_d;
      ovf_q         <= ovf_d;
    end
  end

  assign sw_stable = stable_q;
  assign seq_data  = data_q;
  assign seq_len   = len_q;
  assign seq_done  = (state_q == DONE);
  assign overflow  = ovf_q;

endmodule

// File: doc/switch_sequence_recorder.md
Name: switch_sequence_recorder

Overview:
- Upstream input stage for the Simon Says game on the DE10-Lite.
- Synchronises and debounces the 8 slide switches, then records the order in which the switches are turned on during a capture window.
- Presents the recorded ordered sequence and its length to the downstream player-store/compare logic.
- A bare on/off bitmask cannot distinguish order; this block adds that capability.

Parameters:
- DEB_CYCLES, 500000: consecutive clk cycles a synchronised switch level must persist before the debounced level updates (10 ms at 50 MHz).
- DEPTH, 8: maximum number of sequence entries.
- IDX_W, 3: width of one entry (switch index 0..7).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  reset, synchronous, active-low.
- sw  in  8  raw asynchronous slide switches; bit n = SWn.
- arm  in  1  start a new capture window. Sampled as a level.
- close  in  1  end the capture window, driven by timer expiry or check. Sampled as a level.
- sw_stable  out  8  debounced switch levels.
- seq_data  out  DEPTH*IDX_W  recorded indices. Entry k occupies bits [k*IDX_W +: IDX_W]; entry 0 is the first switch turned on.
- seq_len  out  4  number of valid entries, 0..DEPTH.
- seq_done  out  1  high while the sequence is final.
- overflow  out  1  a rise occurred while the buffer was full, or pending rises were discarded at close.

Behaviour:
- **Reset.** While reset=0 at a clk edge, every register clears:
  - sw_stable=0, seq_data=0, seq_len=0, seq_done=0, overflow=0.
  - Synchroniser flops=0, debounce counters=0, pending mask=0.
  - FSM goes to IDLE.
  - Reset mid-capture discards all entries; nothing is retained.
- **Synchroniser.** Two flops per switch bit.
- **Debounce, per bit.**
  - If the synchronised value equals sw_stable[n], the counter clears.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1, sw_stable[n] takes the synchronised value and the counter clears.
  - Latency from raw change to sw_stable change: 2 + DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES cycles never changes sw_stable.
- **Rise detect.** rise[n] = sw_stable[n] & ~sw_stable_d[n]. Falls are ignored; turning a switch off and on again records it again.
- **Pending mask.** Rises OR into an 8-bit pending mask every cycle, in all states. The mask is cleared on leaving CAPTURE and on entering CAPTURE.
- **FSM.**
  - IDLE:
    - seq_done=0.
    - arm=1 → clear seq_data, seq_len, overflow and pending → CAPTURE.
  - CAPTURE:
    - Each cycle, if pending≠0, the lowest set index is removed from pending.
    - If seq_len<DEPTH, that index is written at entry seq_len and seq_len increments (one append per cycle).
    - If seq_len==DEPTH, the index is dropped and overflow=1 (sticky).
    - Rises occurring the same cycle as an append are added to pending, never lost.
    - Stable-rise to seq_len increment latency: 1 cycle when pending is otherwise empty.
    - close=1 → DONE. An append scheduled that same cycle still completes. Any remaining pending bits are discarded and set overflow=1.
  - DONE:
    - seq_done=1. seq_data, seq_len and overflow are frozen.
    - arm=1 → clear as in IDLE → CAPTURE, with seq_done=0 the next cycle.
    - reset is the only other exit (→ IDLE).
- **Simultaneous arm and close.**
  - In IDLE or DONE, arm has priority.
  - In CAPTURE, arm is ignored and close is honoured.
- **Output timing.** seq_data and seq_len are registered outputs and remain valid in every state. Entries at index ≥ seq_len read 0.

Test Plan (DEB_CYCLES=4 for simulation):
1. **Reset.** Hold reset=0 for 3 cycles with sw=8'hFF → all outputs 0 and FSM IDLE. Release reset → sw_stable=8'hFF after 6 cycles; seq_len stays 0 because not armed.
2. **Ordered capture.** Pulse arm, then raise SW3, SW0, SW5 at 20-cycle intervals, then close → seq_len=3, entries 3,0,5, seq_done=1, overflow=0.
3. **Simultaneous rise.** In CAPTURE, raise SW6 and SW2 on the same cycle → entries 2 then 6 on consecutive cycles, seq_len=2.
4. **Bounce.** In CAPTURE, toggle SW1 with pulses of 3 cycles → sw_stable[1] unchanged, seq_len=0. Then hold SW1 high → exactly one entry, value 1.
5. **Overflow.** In CAPTURE, produce 9 rises by cycling SW0 off/on → seq_len=8, all entries 0, overflow=1.
6. **Re-arm and reset.** Re-arm from DONE → seq_len=0 and seq_done=0 next cycle. Reset asserted mid-CAPTURE with seq_len=2 → seq_len=0 and FSM IDLE; a subsequent close has no effect.
